metadata_arbiter: RTL and testbench
===================================

// Module: metadata_arbiter
// PURPOSE
//   Round-robin arbiter sharing one downstream metadata bus among NUM_LANES parser lanes.
//   Each lane holds a latched metadata record plus a valid flag from its own packager.
//   The arbiter grants one lane per cycle, registers the record into a valid/ready output
//   stage, and returns a one-cycle ack so the lane can release the record.
// PARAMETERS
//   NUM_LANES  4   requesting parser lanes, 2..8
//   CNT_W      16  width of per-lane grant counters (only with METADATA_ARB_STATS_EN)
// PORTS
//   clk            in   1                  clock; all logic rises on posedge
//   rst_n          in   1                  asynchronous, active-low reset
//   lane_valid     in   NUM_LANES          lane i holds a valid record; stays high until ack
//   lane_meta      in   NUM_LANES*META_W   packed meta_t per lane; lane i at [i*META_W +: META_W]
//   lane_ack       out  NUM_LANES          one-cycle pulse: record from lane i captured
//   out_valid      out  1                  output record valid
//   out_ready      in   1                  downstream accepts when out_valid && out_ready
//   out_meta       out  META_W             granted record (meta_t)
//   out_lane_id    out  $clog2(NUM_LANES)  source lane of out_meta
//   stat_grant_cnt out  NUM_LANES*CNT_W    per-lane grant counters; zero without the macro
// BEHAVIOUR
//   - Reset values: out_valid=0, out_meta=0, out_lane_id=0, lane_ack=0, rr_ptr=0, counters=0.
//     Reset mid-transfer drops the held record; lanes keep lane_valid high and are re-granted.
//   - Output slot:
//     - load_ok = !out_valid || out_ready.
//     - When load_ok and a lane is eligible, the slot loads the record at the next edge.
//     - When load_ok and no lane is eligible, the slot clears out_valid at the next edge.
//   - Eligibility: eligible[i] = lane_valid[i] && !lane_ack[i].
//     - The lane acked in the previous cycle is masked, so a lane whose valid is still
//       high during its ack cycle is never granted twice.
//   - Grant is combinational: the first eligible lane scanning rr_ptr, rr_ptr+1, ... mod NUM_LANES.
//   - At the load edge:
//     - out_meta and out_lane_id are loaded from the granted lane.
//     - out_valid is set to 1.
//     - lane_ack[g] is set to 1 for exactly one cycle; all other ack bits are 0.
//     - rr_ptr becomes (g+1) mod NUM_LANES.
//   - Latency: lane_valid rising -> out_valid one cycle later, provided the slot is free and the lane wins.
//   - Throughput: one record per cycle with out_ready held high (back-to-back loads, no bubble).
//   - Backpressure: while out_valid && !out_ready:
//     - out_meta and out_lane_id hold stable.
//     - No ack is issued and rr_ptr holds.
//   - Fairness: a continuously valid lane waits at most NUM_LANES-1 grants.
//   - Grant mux is one-hot, and at most one lane_ack bit is set in any cycle.
//   - Simultaneous drain and load in the same cycle is legal; out_valid stays 1.
//   - Protocol check (simulation only): a lane dropping lane_valid before its ack raises $error.
// CONFIGURATION
//   METADATA_ARB_STATS_EN defined:
//     - Each CNT_W-bit counter increments on its lane's ack.
//     - Counters saturate at all-ones and do not wrap.
//   Not defined: no counter logic; stat_grant_cnt is tied to 0.
// STRUCTURE
//   etherparse_pkg holds the shared types:
//     - typedef struct packed meta_t:
//       - dest_mac[47:0], src_mac[47:0], ethertype[15:0]
//       - vlan_present, vlan_id[11:0], l2_header_len[4:0]
//       - is_ipv4, is_ipv6, is_arp, is_unknown
//     - localparam META_W = $bits(meta_t) = 134.
//   Sub-module rr_arbiter (req, ptr -> one-hot gnt, gnt_idx, any):
//     - Purely combinational.
//     - Shared with future schedulers.
// TESTING
//   1. Lane 2 only:
//      - Stimulus: lane_valid=0100, dest_mac=DEADBEEFCAFE, out_ready=1.
//      - Response: next cycle out_valid=1, out_lane_id=2, out_meta.dest_mac=DEADBEEFCAFE,
//        lane_ack=0100 for one cycle only.
//   2. All lanes valid continuously, out_ready=1:
//      - Grant order is 0,1,2,3,0.
//      - No bubble between grants; no lane acked twice in a row.
//   3. Backpressure:
//      - Stimulus: out_ready=0 for 5 cycles with lanes 1 and 3 valid.
//      - Response: out_meta and out_lane_id hold; lane_ack stays 0.
//      - After out_ready=1: lane 3 granted next, then lane 1 (rr_ptr was 2 after the prior lane-1 grant).
//   4. Reset mid-transfer:
//      - Stimulus: assert rst_n=0 while out_valid=1.
//      - Response: all outputs 0 the same cycle.
//      - After release: the same held lane is granted again.
//   5. METADATA_ARB_STATS_EN with CNT_W=4:
//      - 20 grants to lane 0 -> stat_grant_cnt[3:0]=F (saturated).
//      - Without the macro -> stat_grant_cnt=0.

Source files
------------

// File: rtl/etherparse_pkg.sv
// Shared parser-side types: the per-packet L2 metadata record handed between lanes and the arbiter.
package etherparse_pkg;

  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        vlan_present;
    logic [11:0] vlan_id;
    logic [4:0]  l2_header_len;
    logic        is_ipv4;
    logic        is_ipv6;
    logic        is_arp;
    logic        is_unknown;
  } meta_t;

  localparam int META_W = $bits(meta_t);

  // Index width that stays legal for single-entry configurations.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/metadata_arbiter_if.sv
// Lane request/ack bundle plus valid/ready metadata output bus of metadata_arbiter.
interface metadata_arbiter_if
  import etherparse_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 16
) ();
  localparam int LID_W = idx_width(NUM_LANES);

  logic [NUM_LANES-1:0]        lane_valid;
  logic [NUM_LANES*META_W-1:0] lane_meta;
  logic [NUM_LANES-1:0]        lane_ack;
  logic                        out_valid;
  logic                        out_ready;
  meta_t                       out_meta;
  logic [LID_W-1:0]            out_lane_id;
  logic [NUM_LANES*CNT_W-1:0]  stat_grant_cnt;

  modport master (
    input  lane_valid, lane_meta, out_ready,
    output lane_ack, out_valid, out_meta, out_lane_id, stat_grant_cnt
  );

  modport slave (
    output lane_valid, lane_meta, out_ready,
    input  lane_ack, out_valid, out_meta, out_lane_id, stat_grant_cnt
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit scanning ptr, ptr+1, ... mod N; one-hot gnt.
// Zero latency; no state, so holding ptr holds the priority order.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] w_j;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(ptr) + k) % N);
      if (req[w_j]) begin
        gnt     = {{(N-1){1'b0}}, 1'b1} << w_j;
        gnt_idx = w_j;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/metadata_arbiter.sv
// Round-robin share of one metadata bus among lanes; 1-cycle lane_valid->out_valid, ack pulse on load.
// Backpressure holds out_meta/out_lane_id, acks and rr_ptr; METADATA_ARB_STATS_EN adds saturating grant counters.
module metadata_arbiter
  import etherparse_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  metadata_arbiter_if.master  bus
);
  localparam int LID_W = idx_width(NUM_LANES);

  logic [NUM_LANES-1:0] r_ack;
  logic [NUM_LANES-1:0] w_elig;
  logic [NUM_LANES-1:0] w_gnt;
  logic [LID_W-1:0]     r_rr_ptr;
  logic [LID_W-1:0]     r_lane_id;
  logic [LID_W-1:0]     w_gnt_idx;
  logic [LID_W-1:0]     w_ptr_nxt;
  logic                 r_out_valid;
  logic                 w_any;
  logic                 w_load_ok;
  logic                 w_load;
  meta_t                r_out_meta;
  logic [META_W-1:0]    w_sel_raw;

  // A lane still showing valid during its ack cycle is holding the record just taken.
  assign w_elig    = bus.lane_valid & ~r_ack;
  assign w_load_ok = !r_out_valid || bus.out_ready;
  assign w_load    = w_load_ok && w_any;
  assign w_ptr_nxt = (w_gnt_idx == LID_W'(NUM_LANES - 1)) ? '0 : w_gnt_idx + 1'b1;

  rr_arbiter #(
    .N  (NUM_LANES),
    .IW (LID_W)
  ) u_rr (
    .req     (w_elig),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  always_comb begin
    w_sel_raw = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_gnt[i]) w_sel_raw = w_sel_raw | bus.lane_meta[i*META_W +: META_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_meta  <= '0;
      r_lane_id   <= '0;
      r_rr_ptr    <= '0;
      r_ack       <= '0;
    end else begin
      r_ack <= w_load ? w_gnt : '0;
      if (w_load_ok) begin
        r_out_valid <= w_any;
        if (w_any) begin
          r_out_meta <= meta_t'(w_sel_raw);
          r_lane_id  <= w_gnt_idx;
          r_rr_ptr   <= w_ptr_nxt;
        end
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_meta    = r_out_meta;
  assign bus.out_lane_id = r_lane_id;
  assign bus.lane_ack    = r_ack;

`ifdef METADATA_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt [NUM_LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (r_ack[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    bus.stat_grant_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) bus.stat_grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
  end
`else
  assign bus.stat_grant_cnt = {(NUM_LANES*CNT_W){1'b0}};
`endif

  // A lane may release its record only in or right after its ack cycle.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_chk
    a_valid_hold: assert property (@(posedge clk) disable iff (!rst_n)
      $fell(bus.lane_valid[gi]) |-> (r_ack[gi] || $past(r_ack[gi])))
      else $error("lane %0d dropped lane_valid before its ack", gi);
  end

  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_ack))
    else $error("more than one lane_ack bit set");

endmodule

// File: tb/tb_metadata_arbiter.sv
// Directed bench for metadata_arbiter: reset, single lane, round robin, backpressure, reset mid-transfer, stats.
module tb_metadata_arbiter;
  import etherparse_pkg::*;

  localparam int NL = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  metadata_arbiter_if #(.NUM_LANES(NL), .CNT_W(CW)) bus ();

  metadata_arbiter #(.NUM_LANES(NL), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic meta_t mk_meta(input logic [47:0] dmac, input int lane);
    meta_t m;
    m               = '0;
    m.dest_mac      = dmac;
    m.src_mac       = 48'h0200_0000_0000 + 48'(lane);
    m.ethertype     = 16'h0800;
    m.vlan_present  = lane[0];
    m.vlan_id       = 12'h100 + 12'(lane);
    m.l2_header_len = 5'd14;
    m.is_ipv4       = 1'b1;
    return m;
  endfunction

  task automatic set_meta(input int lane, input meta_t m);
    bus.lane_meta[lane*META_W +: META_W] = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.lane_valid = '0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int    order [5];
    meta_t m_a;
    meta_t m_b;
    logic [NL*CW-1:0] exp_stat;

    order = '{0, 1, 2, 3, 0};

    // Reset state
    rst_n          = 1'b0;
    bus.lane_valid = '0;
    bus.lane_meta  = '0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_meta", bus.out_meta, 0);
    chk("rst_lane_id", bus.out_lane_id, 0);
    chk("rst_lane_ack", bus.lane_ack, 0);
    chk("rst_stat", bus.stat_grant_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Lane 2 alone
    m_a = mk_meta(48'hDEAD_BEEF_CAFE, 2);
    set_meta(2, m_a);
    bus.lane_valid = 4'b0100;
    bus.out_ready  = 1'b1;
    tick();
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_lane_id", bus.out_lane_id, 2);
    chk("t1_dest_mac", bus.out_meta.dest_mac, 48'hDEAD_BEEF_CAFE);
    chk("t1_meta", bus.out_meta, m_a);
    chk("t1_ack", bus.lane_ack, 4'b0100);
    bus.lane_valid = '0;
    tick();
    chk("t1_ack_off", bus.lane_ack, 0);
    chk("t1_drain", bus.out_valid, 0);

    // All lanes continuously valid
    do_reset();
    for (int i = 0; i < NL; i++) set_meta(i, mk_meta(48'h0000_0000_1000 + 48'(i), i));
    bus.lane_valid = 4'b1111;
    bus.out_ready  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_valid", bus.out_valid, 1);
      chk("t2_lane_id", bus.out_lane_id, order[k]);
      chk("t2_ack", bus.lane_ack, 4'b0001 << order[k]);
      chk("t2_dest_mac", bus.out_meta.dest_mac, 48'h0000_0000_1000 + 48'(order[k]));
    end

    // Backpressure with lanes 1 and 3
    do_reset();
    set_meta(1, mk_meta(48'h1111_1111_1111, 1));
    set_meta(3, mk_meta(48'h3333_3333_3333, 3));
    bus.lane_valid = 4'b0010;
    bus.out_ready  = 1'b1;
    tick();
    chk("t3_first_id", bus.out_lane_id, 1);
    chk("t3_first_ack", bus.lane_ack, 4'b0010);
    set_meta(1, mk_meta(48'h1212_1212_1212, 1));
    bus.lane_valid = 4'b1010;
    bus.out_ready  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_valid", bus.out_valid, 1);
      chk("t3_hold_id", bus.out_lane_id, 1);
      chk("t3_hold_mac", bus.out_meta.dest_mac, 48'h1111_1111_1111);
      chk("t3_hold_ack", bus.lane_ack, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t3_next_id", bus.out_lane_id, 3);
    chk("t3_next_ack", bus.lane_ack, 4'b1000);
    chk("t3_next_mac", bus.out_meta.dest_mac, 48'h3333_3333_3333);
    bus.lane_valid = 4'b0010;
    tick();
    chk("t3_last_id", bus.out_lane_id, 1);
    chk("t3_last_ack", bus.lane_ack, 4'b0010);
    chk("t3_last_mac", bus.out_meta.dest_mac, 48'h1212_1212_1212);
    bus.lane_valid = '0;
    tick();
    chk("t3_empty", bus.out_valid, 0);

    // Reset while a record is held
    do_reset();
    m_b = mk_meta(48'h4444_5555_6666, 2);
    set_meta(2, m_b);
    bus.lane_valid = 4'b0100;
    bus.out_ready  = 1'b0;
    tick();
    chk("t4_pre_valid", bus.out_valid, 1);
    chk("t4_pre_ack", bus.lane_ack, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", bus.out_valid, 0);
    chk("t4_rst_meta", bus.out_meta, 0);
    chk("t4_rst_id", bus.out_lane_id, 0);
    chk("t4_rst_ack", bus.lane_ack, 0);
    tick();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("t4_regrant_valid", bus.out_valid, 1);
    chk("t4_regrant_id", bus.out_lane_id, 2);
    chk("t4_regrant_ack", bus.lane_ack, 4'b0100);
    chk("t4_regrant_meta", bus.out_meta, m_b);
    bus.lane_valid = '0;
    tick();

    // Grant counters: 20 grants to lane 0
    do_reset();
    set_meta(0, mk_meta(48'h0A0A_0A0A_0A0A, 0));
    bus.lane_valid = 4'b0001;
    bus.out_ready  = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("t5_ack", bus.lane_ack, 4'b0001);
      if (n == 19) bus.lane_valid = '0;
      tick();
      if (n == 2) begin
`ifdef METADATA_ARB_STATS_EN
        exp_stat = 16'h0003;
`else
        exp_stat = '0;
`endif
        chk("t5_stat_3", bus.stat_grant_cnt, exp_stat);
      end
    end
`ifdef METADATA_ARB_STATS_EN
    exp_stat = 16'h000F;
`else
    exp_stat = '0;
`endif
    chk("t5_stat_sat", bus.stat_grant_cnt, exp_stat);
    chk("t5_idle", bus.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
